// File: rtl/vec_sweep_pkg.sv
// Shared types and helpers for the vector sweep checker.
// Holds the FSM state encoding, the default truth table and the table lookup.
package vec_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Lookup works on a zero-extended table so one function serves any
    // parameterisation up to these limits.
    localparam int TBL_MAX = 256;
    localparam int OUT_MAX = 8;

    // Full-adder sum/carry packed as {x,y} per vector.
    localparam logic [15:0] DEFAULT_EXP_TABLE = 16'hD668;

    function automatic logic [OUT_MAX-1:0] exp_lookup(
        input logic [TBL_MAX-1:0] tbl,
        input int unsigned        idx,
        input int unsigned        n_out
    );
        logic [TBL_MAX-1:0] sh;
        logic [OUT_MAX-1:0] mask;
        sh   = tbl >> (idx * n_out);
        mask = ~({OUT_MAX{1'b1}} << n_out);
        return sh[OUT_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/vec_sweep_settle_timer.sv
// Settle-window counter: pulses expire on the last settle clock of a vector.
// Latency: expire is combinational on the SETTLE_CYCLES-th enabled clock; no backpressure.
// Backpressure: none; clear has priority over enable.
module vec_sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] settle_cnt;

    assign expire = enable && (settle_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (clear) begin
            settle_cnt <= '0;
        end else if (enable) begin
            settle_cnt <= expire ? '0 : settle_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/vec_sweep_checker.sv
// Sweeps every stim vector in ascending order, samples resp after a settle window, checks a truth table.
// Latency: 2^N_IN*(SETTLE_CYCLES+1) clocks from start to the done pulse; start ignored while running.
// Backpressure: none. VEC_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module vec_sweep_checker
    import vec_sweep_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int N_OUT         = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = DEFAULT_EXP_TABLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  fail_vec,
    output logic [N_OUT-1:0] fail_resp
);

    localparam logic [N_IN-1:0] STIM_LAST = '1;
    localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

    state_t             state;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_expire;
    logic [OUT_MAX-1:0] exp_cur;
    logic [OUT_MAX-1:0] resp_ext;
    logic               mismatch;
    logic               stop_now;

    assign timer_clear = ((state == IDLE) && start) || (state == SAMPLE);
    assign timer_en    = (state == SETTLE);

    vec_sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .enable(timer_en),
        .expire(timer_expire)
    );

    // stim only moves between sample windows, so resp here reflects a fully settled vector.
    assign exp_cur  = exp_lookup(TBL_MAX'(EXP_TABLE), int'(stim), N_OUT);
    assign resp_ext = OUT_MAX'(resp);
    assign mismatch = (resp_ext != exp_cur);

`ifdef VEC_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_resp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        stim      <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        fail_vec  <= '0;
                        fail_resp <= '0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (err_count == '0) begin
                            fail_vec  <= stim;
                            fail_resp <= resp;
                        end
                    end
                    if ((stim == STIM_LAST) || stop_now) begin
                        // Verdict folds in this final sample, visible alongside done.
                        pass  <= (err_count == '0) && !mismatch;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        stim  <= stim + STIM_ONE;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
